// File: rtl/pipe_pkg.sv
// Shared opcode, control-bundle and forwarding definitions for the pipeline sequencer.
package pipe_pkg;

  localparam logic [2:0] OP_LDM = 3'b001;
  localparam logic [2:0] OP_STR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  localparam int CTRL_W     = 6;
  localparam int CTRL_WB    = 5;
  localparam int CTRL_ALU   = 4;
  localparam int CTRL_MR    = 3;
  localparam int CTRL_MW    = 2;
  localparam int CTRL_ALUOP = 1;
  localparam int CTRL_IMM   = 0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_e;

  function automatic logic uses_rs1(input logic [2:0] op);
    return (op == OP_STR) || (op == OP_ADD) || (op == OP_NOT);
  endfunction

  function automatic logic uses_rs2(input logic [2:0] op);
    return (op == OP_STR) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: loads its payload every cycle, or a cleared bubble.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         bubble_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = !bubble_i;
    data_d  = bubble_i ? '0 : data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stages CU bundles, detects load-use and memory-port hazards,
// selects EX operand forwarding and counts stall cycles.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [2:0]        id_op,
  input  logic [5:0]        id_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_bubble,
  output logic [5:0]        ex_ctrl,
  output logic [5:0]        mem_ctrl,
  output logic [5:0]        wb_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              imem_grant,
  output logic              dmem_grant,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Payload layout: {ctrl, rd, rs1, rs2, uses_rs1, uses_rs2}
  localparam int PW  = CTRL_W + 3 * REG_AW + 2;
  localparam int SRC = PW - CTRL_W - REG_AW;

  logic [PW-1:0]     id_pl, ex_pl, mem_pl, wb_pl;
  logic              ex_v, mem_v, wb_v;
  logic [CTRL_W-1:0] ex_c, mem_c, wb_c;
  logic [REG_AW-1:0] ex_rd_r, mem_rd_r, wb_rd_r, ex_rs1, ex_rs2;
  logic              ex_u1, ex_u2;
  logic [SRC-1:0]    mem_unused_src, wb_unused_src;
  logic              id_hit, lu, mc, mem_fwd_ok, wb_fwd_ok;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign id_pl = {id_ctrl, id_rd, id_rs1, id_rs2, uses_rs1(id_op), uses_rs2(id_op)};

  pipe_stage_reg #(.W(PW)) u_idex (
    .clk_i(clk), .rst_ni(rst_n), .bubble_i(!id_valid || lu),
    .data_i(id_pl), .valid_o(ex_v), .data_o(ex_pl)
  );
  pipe_stage_reg #(.W(PW)) u_exmem (
    .clk_i(clk), .rst_ni(rst_n), .bubble_i(!ex_v),
    .data_i(ex_pl), .valid_o(mem_v), .data_o(mem_pl)
  );
  pipe_stage_reg #(.W(PW)) u_memwb (
    .clk_i(clk), .rst_ni(rst_n), .bubble_i(!mem_v),
    .data_i(mem_pl), .valid_o(wb_v), .data_o(wb_pl)
  );

  assign {ex_c, ex_rd_r, ex_rs1, ex_rs2, ex_u1, ex_u2} = ex_pl;
  assign {mem_c, mem_rd_r, mem_unused_src}            = mem_pl;
  assign {wb_c, wb_rd_r, wb_unused_src}               = wb_pl;

  // Hazard detection: a load in EX feeding ID stalls; a load/store in MEM steals the port.
  assign id_hit = (uses_rs1(id_op) && (ex_rd_r == id_rs1)) ||
                  (uses_rs2(id_op) && (ex_rd_r == id_rs2));
  assign lu = ex_v && ex_c[CTRL_MR] && ex_c[CTRL_WB] && id_valid && id_hit;
  assign mc = mem_v && (mem_c[CTRL_MR] || mem_c[CTRL_MW]);

  assign pc_en       = !(lu || mc);
  assign ifid_en     = !lu;
  assign ifid_bubble = mc && !lu;
  assign dmem_grant  = mc;
  assign imem_grant  = !mc;

  // A load in MEM has no result yet, so only a non-load EX/MEM producer may forward.
  assign mem_fwd_ok = mem_v && mem_c[CTRL_WB] && !mem_c[CTRL_MR];
  assign wb_fwd_ok  = wb_v && wb_c[CTRL_WB];

  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (ex_v && ex_u1) begin
      if (mem_fwd_ok && (mem_rd_r == ex_rs1))     fwd_a = FWD_MEM;
      else if (wb_fwd_ok && (wb_rd_r == ex_rs1))  fwd_a = FWD_WB;
    end
    if (ex_v && ex_u2) begin
      if (mem_fwd_ok && (mem_rd_r == ex_rs2))     fwd_b = FWD_MEM;
      else if (wb_fwd_ok && (wb_rd_r == ex_rs2))  fwd_b = FWD_WB;
    end
  end

  assign ex_ctrl  = ex_v  ? ex_c  : '0;
  assign mem_ctrl = mem_v ? mem_c : '0;
  assign wb_ctrl  = wb_v  ? wb_c  : '0;
  assign ex_rd    = ex_rd_r;
  assign mem_rd   = mem_rd_r;
  assign wb_rd    = wb_rd_r;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
